// File: rtl/action_mapper.sv
// action_mapper: turns PS/2 scancodes, mouse button levels and gyro samples
// into per-player action vectors (registered levels plus 1-cycle rise pulses).
// Ports:
//   clk, rst        clock, async active-high reset
//   scancode        PS/2 byte, qualified by scancode_valid (1-cycle strobe)
//   mouse_btn       mouse button levels {M,R,L} -> MOUSE_PLAYER bits [2:0]
//   angular_v       signed gyro sample, qualified by angular_valid
//   clear           sync: drop held keys, abort swing, reset prefix decoder
//   input_signal    [p*ACTION_W+a] registered action levels
//   action_rise     [p*ACTION_W+a] 1-cycle pulse on 0->1 of input_signal
//   kbd_error       1-cycle pulse after a keyboard error byte (00/FF)
module action_mapper #(
  parameter int unsigned NUM_PLAYERS   = 4,
  parameter int unsigned ACTION_W      = 6,
  parameter logic [NUM_PLAYERS*ACTION_W-1:0][8:0] KEYMAP = '0,
  parameter int unsigned MOUSE_PLAYER  = 0,
  parameter int unsigned SENSOR_PLAYER = 1,
  parameter int unsigned SWING_BIT     = 5,
  parameter logic [15:0] SWING_THRESH  = 16'd2000,
  parameter logic [15:0] SWING_HYST    = 16'd500,
  parameter int unsigned SWING_PULSE   = 8,
  parameter int unsigned PREFIX_TMO    = 65535
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [7:0]                      scancode,
  input  logic                            scancode_valid,
  input  logic [2:0]                      mouse_btn,
  input  logic [15:0]                     angular_v,
  input  logic                            angular_valid,
  input  logic                            clear,
  output logic [NUM_PLAYERS*ACTION_W-1:0] input_signal,
  output logic [NUM_PLAYERS*ACTION_W-1:0] action_rise,
  output logic                            kbd_error
);

  localparam int unsigned N       = NUM_PLAYERS * ACTION_W;
  localparam int unsigned TMO_W   = $clog2(PREFIX_TMO + 1);
  localparam int unsigned PULSE_W = $clog2(SWING_PULSE + 1);
  localparam logic [15:0] REARM   = SWING_THRESH - SWING_HYST;

  typedef enum logic [1:0] {P_IDLE, P_EXT, P_BRK, P_EXT_BRK} pfx_t;
  typedef enum logic [1:0] {S_ARMED, S_FIRE, S_COOL} swing_t;

  pfx_t               pfx_q, pfx_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [N-1:0]       key_q, key_d;
  logic               err_d;
  swing_t             swg_q, swg_d;
  logic [PULSE_W-1:0] pcnt_q, pcnt_d;
  logic [15:0]        abs_v;
  logic               swing;
  logic [N-1:0]       next_sig;
  logic [ACTION_W-1:0] mouse_vec;

  // Prefix decoder and key-held table
  always_comb begin
    logic       do_make, do_brk, ext;
    logic [8:0] code;
    pfx_d   = pfx_q;
    tmo_d   = tmo_q;
    key_d   = key_q;
    err_d   = 1'b0;
    do_make = 1'b0;
    do_brk  = 1'b0;
    ext     = 1'b0;
    if (clear) begin
      pfx_d = P_IDLE;
      tmo_d = '0;
      key_d = '0;
    end else if (scancode_valid) begin
      tmo_d = '0;
      if (scancode == 8'h00 || scancode == 8'hFF) begin
        key_d = '0;
        err_d = 1'b1;
        pfx_d = P_IDLE;
      end else if (scancode != 8'hE1) begin
        // E1 (Pause) is swallowed without touching the decoder state
        unique case (pfx_q)
          P_IDLE: begin
            if (scancode == 8'hE0)      pfx_d = P_EXT;
            else if (scancode == 8'hF0) pfx_d = P_BRK;
            else                        do_make = 1'b1;
          end
          P_EXT: begin
            ext = 1'b1;
            if (scancode == 8'hF0)      pfx_d = P_EXT_BRK;
            else if (scancode != 8'hE0) do_make = 1'b1;
          end
          P_BRK: begin
            if (scancode != 8'hE0 && scancode != 8'hF0) do_brk = 1'b1;
          end
          default: begin
            ext = 1'b1;
            if (scancode != 8'hE0 && scancode != 8'hF0) do_brk = 1'b1;
          end
        endcase
      end
      code = {ext, scancode};
      if (do_make || do_brk) begin
        pfx_d = P_IDLE;
        for (int unsigned i = 0; i < N; i++) begin
          if (KEYMAP[i] != 9'h000 && KEYMAP[i] == code) key_d[i] = do_make;
        end
      end
    end else if (pfx_q != P_IDLE) begin
      // A half-received prefix is dropped after PREFIX_TMO quiet cycles
      if (tmo_q == TMO_W'(PREFIX_TMO)) begin
        pfx_d = P_IDLE;
        tmo_d = '0;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
  end

  // Saturating magnitude of the gyro sample
  always_comb begin
    if (!angular_v[15])              abs_v = angular_v;
    else if (angular_v == 16'h8000)  abs_v = 16'h7FFF;
    else                             abs_v = ~angular_v + 16'd1;
  end

  // Swing detector with hysteresis
  always_comb begin
    swg_d  = swg_q;
    pcnt_d = pcnt_q;
    unique case (swg_q)
      S_ARMED: begin
        if (angular_valid && abs_v >= SWING_THRESH) begin
          swg_d  = S_FIRE;
          pcnt_d = PULSE_W'(SWING_PULSE);
        end
      end
      S_FIRE: begin
        if (pcnt_q <= PULSE_W'(1)) begin
          swg_d  = S_COOL;
          pcnt_d = '0;
        end else begin
          pcnt_d = pcnt_q - PULSE_W'(1);
        end
      end
      S_COOL: begin
        if (angular_valid && abs_v < REARM) swg_d = S_ARMED;
      end
      default: swg_d = S_ARMED;
    endcase
    if (clear) begin
      swg_d  = S_COOL;
      pcnt_d = '0;
    end
  end

  assign swing     = (swg_q == S_FIRE);
  assign mouse_vec = ACTION_W'(mouse_btn);

  // OR together keyboard, mouse and gyro sources
  always_comb begin
    next_sig = key_q;
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      for (int unsigned a = 0; a < ACTION_W; a++) begin
        if (p == MOUSE_PLAYER && a < 3)
          next_sig[p*ACTION_W+a] = next_sig[p*ACTION_W+a] | mouse_vec[a];
        if (p == SENSOR_PLAYER && a == SWING_BIT)
          next_sig[p*ACTION_W+a] = next_sig[p*ACTION_W+a] | swing;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pfx_q        <= P_IDLE;
      tmo_q        <= '0;
      key_q        <= '0;
      swg_q        <= S_ARMED;
      pcnt_q       <= '0;
      input_signal <= '0;
      action_rise  <= '0;
      kbd_error    <= 1'b0;
    end else begin
      pfx_q        <= pfx_d;
      tmo_q        <= tmo_d;
      key_q        <= key_d;
      swg_q        <= swg_d;
      pcnt_q       <= pcnt_d;
      input_signal <= next_sig;
      action_rise  <= next_sig & ~input_signal;
      kbd_error    <= err_d;
    end
  end

endmodule
